// File: rtl/stream_min_finder.sv
// stream_min_finder
//
// Groups a valid/ready stream of unsigned samples into frames of FRAME_LEN
// samples. For each frame it finds the minimum sample and the 0-based position
// of that sample. On a tie the earliest position wins. The result is then held
// on a valid/ready output until the consumer takes it.
//
// Parameters:
//   WIDTH      sample width in bits (unsigned)
//   FRAME_LEN  samples per frame, 2..256
//   IDX_W      width of the index/counter fields, max(1, clog2(FRAME_LEN));
//              derived, do not override
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current frame or held result
//   in_valid   sample present on in_data
//   in_ready   block accepts a sample this cycle (COLLECT state)
//   in_data    sample value
//   out_valid  frame result present (HOLD state)
//   out_ready  consumer takes the result this cycle
//   out_min    minimum sample of the completed frame
//   out_idx    position of that minimum within the frame
module stream_min_finder #(
  parameter int WIDTH     = 3,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = (FRAME_LEN <= 2) ? 1 : $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] run_min;
  logic [IDX_W-1:0] run_idx;

  // Running result after folding in the sample currently on in_data.
  logic [WIDTH-1:0] cand_min;
  logic [IDX_W-1:0] cand_idx;

  // Both handshake outputs come straight from the state register, so there is
  // no combinational path from in_valid or out_ready.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);

  always_comb begin
    cand_min = run_min;
    cand_idx = run_idx;
    if (cnt == '0) begin
      // The first sample of a frame seeds the running result unconditionally.
      cand_min = in_data;
      cand_idx = '0;
    end else if (in_data < run_min) begin
      // A strict compare keeps the earliest index on ties.
      cand_min = in_data;
      cand_idx = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      cnt     <= '0;
      run_min <= '0;
      run_idx <= '0;
      out_min <= '0;
      out_idx <= '0;
    end else if (clear) begin
      // Abort: the sample presented this cycle is dropped. out_min/out_idx
      // keep stale values, which are meaningless while out_valid is low.
      state <= COLLECT;
      cnt   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            run_min <= cand_min;
            run_idx <= cand_idx;
            if (cnt == LAST_CNT) begin
              out_min <= cand_min;
              out_idx <= cand_idx;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          // The exit edge accepts no sample, because in_ready is still low
          // during this cycle.
          if (out_ready) begin
            state <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_min_finder.sv
// Directed testbench for stream_min_finder with WIDTH=3 and FRAME_LEN=4.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled
// at that same point.
module tb_stream_min_finder;

  localparam int WIDTH     = 3;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = 2;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [IDX_W-1:0] out_idx;

  int check_cnt = 0;
  int pass_cnt  = 0;

  stream_min_finder #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_min  (out_min),
    .out_idx  (out_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int observed, input int expected);
    check_cnt++;
    if (observed == expected) begin
      pass_cnt++;
      $display("check %-24s got %0d exp %0d ok", tag, observed, expected);
    end else begin
      $display("FAIL %-24s got %0d exp %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the result-present state: held outputs, with in_ready low.
  task automatic check_hold(input string tag, input int exp_min, input int exp_idx);
    check({tag, ".out_valid"}, int'(out_valid), 1);
    check({tag, ".in_ready"},  int'(in_ready),  0);
    check({tag, ".out_min"},   int'(out_min),   exp_min);
    check({tag, ".out_idx"},   int'(out_idx),   exp_idx);
  endtask

  // Feed one frame back-to-back with out_ready=1, check the result, and then
  // confirm that out_valid lasted exactly one cycle.
  task automatic run_frame(input string tag, input logic [3:0][2:0] d,
                           input int exp_min, input int exp_idx);
    out_ready = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      tick();
      if (i < FRAME_LEN - 1) check({tag, ".busy"}, int'(out_valid), 0);
    end
    in_valid = 1'b0;
    check_hold(tag, exp_min, exp_idx);
    tick();
    check({tag, ".one_cycle"}, int'(out_valid), 0);
    check({tag, ".ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #12;
    check("reset.in_ready",  int'(in_ready),  1);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.out_min",   int'(out_min),   0);
    check("reset.out_idx",   int'(out_idx),   0);
    rst_n = 1'b1;
    tick();

    // Basic frame and ties/extremes. Index 0 in the array is the first sample.
    run_frame("basic",   {3'd3, 3'd7, 3'd2, 3'd5}, 2, 1);
    run_frame("tie",     {3'd1, 3'd6, 3'd1, 3'd4}, 1, 1);
    run_frame("zeros",   {3'd0, 3'd0, 3'd0, 3'd0}, 0, 0);
    run_frame("sevens",  {3'd7, 3'd7, 3'd7, 3'd7}, 7, 0);

    // Backpressure: HOLD for 5 cycles while in_valid stays high with changing data.
    out_ready = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(6 - i);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      in_data = 3'(i);
      check_hold("bp", 3, 3);
      tick();
    end
    check_hold("bp.end", 3, 3);
    in_data   = 3'd0;
    out_ready = 1'b1;
    tick();
    check("bp.in_ready", int'(in_ready), 1);
    check("bp.out_valid", int'(out_valid), 0);
    // If a HOLD-time zero had been consumed, this frame would give min 0.
    run_frame("bp.next", {3'd6, 3'd7, 3'd6, 3'd5}, 5, 0);

    // Input gaps: 3,_,_,1,_,2,5.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 3'd3; tick();
    in_valid = 1'b0; in_data = 3'd0; tick();
    tick();
    in_valid = 1'b1; in_data = 3'd1; tick();
    in_valid = 1'b0; in_data = 3'd0; tick();
    in_valid = 1'b1; in_data = 3'd2; tick();
    check("gap.not_yet", int'(out_valid), 0);
    in_data = 3'd5; tick();
    in_valid = 1'b0;
    check_hold("gap", 1, 1);
    tick();
    check("gap.one_cycle", int'(out_valid), 0);

    // Clear mid-frame: the zeros before and during clear must be discarded.
    in_valid = 1'b1; in_data = 3'd0; tick();
    tick();
    clear = 1'b1; tick();
    clear = 1'b0;
    run_frame("clr", {3'd4, 3'd5, 3'd6, 3'd7}, 4, 3);

    // Clear while in HOLD.
    out_ready = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    check_hold("clr.hold", 1, 0);
    clear = 1'b1; tick();
    clear = 1'b0;
    check("clr.hold.out_valid", int'(out_valid), 0);
    check("clr.hold.in_ready",  int'(in_ready),  1);
    run_frame("clr.after", {3'd2, 3'd1, 3'd2, 3'd3}, 1, 2);

    // Async reset after 2 samples of a frame, asserted between clock edges.
    in_valid = 1'b1; in_data = 3'd0; tick();
    tick();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.in_ready",  int'(in_ready),  1);
    check("arst.out_valid", int'(out_valid), 0);
    check("arst.out_min",   int'(out_min),   0);
    check("arst.out_idx",   int'(out_idx),   0);
    #2;
    rst_n = 1'b1;
    tick();
    run_frame("arst.after", {3'd0, 3'd1, 3'd3, 3'd2}, 0, 3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/stream_min_finder.md
# stream_min_finder

Sequential front-end for the 3-bit minimum-select datapath. It accepts a stream of unsigned samples over a valid/ready handshake and groups them into fixed-length frames. For each frame it reduces the samples to the minimum value and the position of that value. It then presents the result on a held output handshake to the downstream consumer.

## Interface
- WIDTH, 3, sample width in bits (unsigned).
- FRAME_LEN, 8, samples per frame; legal range 2..256.
- IDX_W, derived = max(1, clog2(FRAME_LEN)), width of index/counter fields.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous abort of the current frame/result.
- in_valid  in  1  sample present on in_data.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  WIDTH  sample value.
- out_valid  out  1  frame result present.
- out_ready  in  1  consumer takes result this cycle.
- out_min  out  WIDTH  minimum sample of the completed frame.
- out_idx  out  IDX_W  0-based position of the minimum within the frame.

## Operation
- Two states: COLLECT (reset state) and HOLD.
- COLLECT: in_ready=1, out_valid=0. A sample is accepted when in_valid && in_ready at the clock edge.
  - Accept with cnt==0: run_min<=in_data, run_idx<=0.
  - Accept with cnt>0: replace only if in_data < run_min (strict), setting run_idx<=cnt. Ties keep the earliest index.
  - cnt increments on every accept.
  - Accept with cnt==FRAME_LEN-1 does the following: the final compare is folded in, out_min/out_idx are loaded with the result, cnt<=0, and the state moves to HOLD.
- HOLD: in_ready=0, out_valid=1. in_valid/in_data are ignored. out_min/out_idx are stable until the transfer completes.
  - out_valid && out_ready moves the state to COLLECT.
- Comparison is unsigned over WIDTH bits. No arithmetic beyond the compare and the cnt increment. cnt never exceeds FRAME_LEN-1, so there is no wrap.
- clear=1 (sync, highest priority after reset): state<=COLLECT, cnt<=0, out_valid drops next cycle. The sample presented in the clear cycle is not accepted, even though in_ready may read 1 that cycle. out_min/out_idx keep their stale values, but they are meaningless while out_valid=0.
- Async reset (any time, including mid-frame or in HOLD) takes effect immediately:
  - state=COLLECT, cnt=0, run_min=0, run_idx=0;
  - out_min=0, out_idx=0, out_valid=0, in_ready=1.
  - The partial frame is discarded.

## Timing
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid/out_ready.
- Latency: out_valid rises on the edge that accepts the FRAME_LEN-th sample, so it is visible in the next cycle.
- Turnaround: the edge where out_ready is sampled high in HOLD returns the state to COLLECT, so in_ready=1 the next cycle. No sample is accepted in the HOLD exit cycle.
- Minimum frame period: FRAME_LEN+1 cycles with in_valid and out_ready held high.
- Backpressure: HOLD persists indefinitely while out_ready=0, and outputs must not change.
- Input gaps (in_valid=0) stall cnt without affecting the running result.
- Reset values: in_ready=1, out_valid=0, out_min=0, out_idx=0.

## Test plan
(WIDTH=3, FRAME_LEN=4 unless stated.)
- Basic frame: in_data 5,2,7,3 on consecutive cycles with out_ready=1 -> out_valid for exactly 1 cycle, out_min=2, out_idx=1. in_ready is 0 for exactly that cycle.
- Ties and extremes: 4,1,6,1 -> min=1, idx=1. Then 0,0,0,0 -> min=0, idx=0. Then 7,7,7,7 -> min=7, idx=0.
- Backpressure: frame 6,5,4,3 with out_ready=0 for 5 cycles, in_valid=1 throughout:
  - out_valid=1 and out_min=3/out_idx=3 are held, and in_ready=0;
  - the in_data changes during HOLD are not consumed;
  - after out_ready=1, in_ready returns to 1 and the next accepted sample is index 0.
- Input gaps: 3,_,_,1,_,2,5 (_ = in_valid low) -> min=1, idx=1. Result appears the cycle after the 5 is accepted.
- Clear: accept 0,0, then assert clear with in_valid=1/in_data=0, then 7,6,5,4 -> min=4, idx=3. The zeros before and during clear must not appear. Also assert clear in HOLD -> out_valid=0 next cycle.
- Async reset: drop rst_n mid-cycle after 2 samples of a frame -> outputs go to reset values immediately without a clock edge. After release, frame 2,3,1,0 -> min=0, idx=3.
